// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory requester:
// op codes, FSM state codes, access sizes and alignment rules.
package lsu_pkg;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_e;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] RESP = 3'd2;
  localparam logic [2:0] ERR  = 3'd3;
  localparam logic [2:0] TOUT = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_store(op_e op);
    return op[2] & (op != LBU);
  endfunction

  function automatic logic [1:0] op_size(op_e op);
    case (op)
      LW, SW:      return SZ_WORD;
      LH, LHU, SH: return SZ_HALF;
      default:     return SZ_BYTE;
    endcase
  endfunction

  function automatic logic is_misaligned(op_e op, logic [1:0] off);
    case (op_size(op))
      SZ_HALF: return off[0];
      SZ_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store byte enables and lane replication,
// plus load lane selection with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  op_e         st_op,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_be,
  output logic [31:0] st_lane_wdata,
  input  op_e         ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_be         = 4'b0000;
    st_lane_wdata = 32'h0;
    case (op_size(st_op))
      SZ_BYTE: begin
        st_be         = 4'b0001 << st_off;
        st_lane_wdata = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_be         = st_off[1] ? 4'b1100 : 4'b0011;
        st_lane_wdata = {2{st_wdata[15:0]}};
      end
      default: begin
        st_be         = 4'b1111;
        st_lane_wdata = st_wdata;
      end
    endcase
  end

  // The addressed lane is moved down to bit 0 before extension.
  always_comb begin
    ld_shifted = ld_word >> {ld_off, 3'b000};
    case (ld_op)
      LB:      ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LBU:     ld_data = {24'h0, ld_shifted[7:0]};
      LH:      ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      LHU:     ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_requester.sv
// Load/store initiator between the MEM stage and word-addressed data memory:
// alignment check, req/ack handshake with timeout, and load data return.
module lsu_mem_requester
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op_type,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [31:0] op_pc,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  output logic        bus_err,
  output logic [31:0] err_pc,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  op_e              op_q, op_d;
  logic [1:0]       off_q, off_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [3:0]       mem_be_q, mem_be_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [31:0]      err_pc_q, err_pc_d;

  op_e         op_in;
  logic [3:0]  be_in;
  logic [31:0] lane_wdata_in;
  logic [31:0] ld_data;

  assign op_in = op_e'(op_type);

  lsu_lane_align u_lane_align (
    .st_op         (op_in),
    .st_off        (op_addr[1:0]),
    .st_wdata      (op_wdata),
    .st_be         (be_in),
    .st_lane_wdata (lane_wdata_in),
    .ld_op         (op_q),
    .ld_off        (off_q),
    .ld_word       (mem_rdata),
    .ld_data       (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    off_d       = off_q;
    pc_d        = pc_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    rdata_d     = 32'h0;
    err_pc_d    = 32'h0;
    case (state_q)
      IDLE: begin
        if (op_valid) begin
          if (is_misaligned(op_in, op_addr[1:0])) begin
            state_d  = ERR;
            err_pc_d = op_pc;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            op_d        = op_in;
            off_d       = op_addr[1:0];
            pc_d        = op_pc;
            mem_addr_d  = {op_addr[31:2], 2'b00};
            mem_be_d    = be_in;
            mem_wdata_d = lane_wdata_in;
            mem_we_d    = is_store(op_in);
          end
        end
      end
      REQ: begin
        // An ack on the final timeout cycle still completes the access.
        if (mem_ack) begin
          state_d = RESP;
          cnt_d   = '0;
          if (!mem_we_q) rdata_d = ld_data;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = TOUT;
          cnt_d    = '0;
          err_pc_d = pc_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP, ERR, TOUT: state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= LW;
      off_q       <= 2'b00;
      pc_q        <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_be_q    <= 4'h0;
      mem_wdata_q <= 32'h0;
      mem_we_q    <= 1'b0;
      rdata_q     <= 32'h0;
      err_pc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      off_q       <= off_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign done      = (state_q == RESP) || (state_q == ERR) || (state_q == TOUT);
  assign addr_err  = state_q == ERR;
  assign bus_err   = state_q == TOUT;
  assign mem_req   = state_q == REQ;
  assign rdata     = rdata_q;
  assign err_pc    = err_pc_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
